// File: rtl/param_delay_line_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with registered rdata (1-cycle latency).
// rdata only updates on re; the array has no reset, so it maps onto block RAM.
module sdp_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/param_delay_line.sv
// Sample-enabled circular-buffer delay line: 1-cycle output latency, delay 1..MAX_DEPTH-1 samples.
// No backpressure: one sample accepted per in_valid cycle; output muted until the buffer refills.
module param_delay_line #(
  parameter int DATA_W    = 16,
  parameter int MAX_DEPTH = 1024,
  parameter int ADDR_W    = $clog2(MAX_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] delay_len,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              primed,
  output logic [ADDR_W-1:0] len_q
);

  localparam logic [ADDR_W-1:0] FILL_MAX = ADDR_W'(MAX_DEPTH - 1);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] fill_cnt;
  logic [ADDR_W-1:0] eff_len;
  logic [ADDR_W-1:0] raddr;
  logic [ADDR_W-1:0] len_nxt;
  logic [ADDR_W-1:0] fill_nxt;
  logic              restart;
  logic              mute;
  logic              mute_q;
  logic [DATA_W-1:0] rdata;

  // A zero delay would read the slot being written; clamp it to one sample.
  assign eff_len = (delay_len == '0) ? ADDR_W'(1) : delay_len;
  assign restart = (eff_len != len_q);
  assign raddr   = wr_ptr - eff_len;

  always_comb begin
    len_nxt  = len_q;
    fill_nxt = fill_cnt;
    mute     = 1'b1;
    if (in_valid) begin
      if (restart) begin
        len_nxt  = eff_len;
        fill_nxt = ADDR_W'(1);
        mute     = 1'b1;
      end else begin
        mute = (fill_cnt < len_q);
        if (fill_cnt != FILL_MAX) fill_nxt = fill_cnt + ADDR_W'(1);
      end
    end
  end

  sdp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (in_valid),
    .waddr (wr_ptr),
    .wdata (in_data),
    .re    (in_valid),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      len_q     <= '0;
      fill_cnt  <= '0;
      out_valid <= 1'b0;
      mute_q    <= 1'b1;
      primed    <= 1'b0;
    end else begin
      out_valid <= in_valid;
      len_q     <= len_nxt;
      fill_cnt  <= fill_nxt;
      primed    <= (len_nxt != '0) && (fill_nxt >= len_nxt);
      if (in_valid) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
        mute_q <= mute;
      end
    end
  end

  // mute_q resets high, so out_data is zero out of reset even though rdata is not reset.
  assign out_data = mute_q ? '0 : rdata;

endmodule

// File: tb/tb_param_delay_line.sv
// Randomised bench for param_delay_line (MAX_DEPTH=16) against a sample-history reference model.
module tb_param_delay_line;

  localparam int DW = 16;
  localparam int MD = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [AW-1:0] delay_len;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          primed;
  logic [AW-1:0] len_q;

  int checks = 0;
  int errors = 0;

  // Reference model: samples since the last restart, applied length, count since restart.
  int            m_len;
  int            m_count;
  logic [DW-1:0] m_hist[$];
  logic          e_valid;
  logic [DW-1:0] e_data;
  logic          e_primed;

  param_delay_line #(
    .DATA_W    (DW),
    .MAX_DEPTH (MD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .delay_len (delay_len),
    .out_valid (out_valid),
    .out_data  (out_data),
    .primed    (primed),
    .len_q     (len_q)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_len    = 0;
    m_count  = 0;
    m_hist.delete();
    e_valid  = 1'b0;
    e_data   = '0;
    e_primed = 1'b0;
  endtask

  // Drive one cycle, advance the model, and return #1 after the active edge.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic [AW-1:0] dl);
    int eff;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    delay_len = dl;
    if (v) begin
      eff = (dl == 0) ? 1 : int'(dl);
      if (eff != m_len) begin
        m_len   = eff;
        m_count = 0;
        m_hist.delete();
      end
      m_hist.push_back(d);
      if (m_hist.size() > MD) void'(m_hist.pop_front());
      m_count++;
      e_data = (m_count > m_len) ? m_hist[m_hist.size() - 1 - m_len] : '0;
    end
    e_valid  = v;
    e_primed = (m_len != 0) && (m_count >= m_len);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    delay_len = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || primed !== 1'b0 || len_q !== '0) begin
      errors++;
      $display("FAIL reset_state valid=%b data=%0h primed=%b len_q=%0d want all zero",
               out_valid, out_data, primed, len_q);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b1, DW'(i), AW'(4));
      checks++;
      if (out_valid !== 1'b1 || out_data !== ((i > 4) ? DW'(i - 4) : DW'(0)) || primed !== (i >= 4)) begin
        errors++;
        $display("FAIL basic i=%0d valid=%b data=%0d primed=%b want 1 %0d %b",
                 i, out_valid, out_data, primed, (i > 4) ? i - 4 : 0, i >= 4);
      end
      checks++;
      if (out_data !== e_data || int'(len_q) !== m_len) begin
        errors++;
        $display("FAIL basic_model i=%0d data=%0d len_q=%0d want %0d %0d", i, out_data, len_q, e_data, m_len);
      end
    end
  endtask

  task automatic test_zero_len();
    logic [DW-1:0] want [3];
    want[0] = 0; want[1] = 10; want[2] = 11;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, DW'(10 + i), AW'(0));
      checks++;
      if (out_data !== want[i] || len_q !== AW'(1) || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL zero_len i=%0d data=%0d len_q=%0d valid=%b want %0d 1 1",
                 i, out_data, len_q, out_valid, want[i]);
      end
    end
  endtask

  task automatic test_gappy();
    logic [DW-1:0] want [4];
    want[0] = 0; want[1] = 0; want[2] = 5; want[3] = 6;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, DW'(5 + i), AW'(2));
      checks++;
      if (out_valid !== 1'b1 || out_data !== want[i]) begin
        errors++;
        $display("FAIL gappy_strobe i=%0d valid=%b data=%0d want 1 %0d", i, out_valid, out_data, want[i]);
      end
      for (int g = 0; g < 2; g++) begin
        cycle(1'b0, DW'($urandom), AW'($urandom));
        checks++;
        if (out_valid !== 1'b0 || out_data !== want[i] || len_q !== AW'(2)) begin
          errors++;
          $display("FAIL gappy_hold i=%0d valid=%b data=%0d len_q=%0d want 0 %0d 2",
                   i, out_valid, out_data, len_q, want[i]);
        end
      end
    end
  endtask

  task automatic test_len_change();
    logic [DW-1:0] first;
    logic [DW-1:0] d;
    first = '0;
    for (int i = 0; i < 10; i++) cycle(1'b1, DW'($urandom), AW'(3));
    checks++;
    if (primed !== 1'b1 || len_q !== AW'(3)) begin
      errors++;
      $display("FAIL len_steady primed=%b len_q=%0d want 1 3", primed, len_q);
    end
    for (int k = 0; k < 8; k++) begin
      d = DW'($urandom);
      if (k == 0) first = d;
      cycle(1'b1, d, AW'(5));
      checks++;
      if ((k < 5 && out_data !== '0) || (k == 5 && out_data !== first) || (k <= 3 && primed !== 1'b0)) begin
        errors++;
        $display("FAIL len_change k=%0d data=%0h primed=%b first=%0h", k, out_data, primed, first);
      end
      checks++;
      if (out_data !== e_data || primed !== e_primed || int'(len_q) !== m_len) begin
        errors++;
        $display("FAIL len_change_model k=%0d data=%0h primed=%b len_q=%0d want %0h %b %0d",
                 k, out_data, primed, len_q, e_data, e_primed, m_len);
      end
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] arr [40];
    for (int n = 0; n < 40; n++) begin
      arr[n] = DW'($urandom);
      cycle(1'b1, arr[n], AW'(15));
      checks++;
      if (out_data !== ((n >= 15) ? arr[n - 15] : DW'(0)) || out_data !== e_data) begin
        errors++;
        $display("FAIL wrap n=%0d data=%0h model=%0h", n, out_data, e_data);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 12; i++) cycle(1'b1, DW'($urandom), AW'(8));
    @(negedge clk);
    in_valid = 1'b1;
    reset    = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || primed !== 1'b0 || len_q !== '0) begin
      errors++;
      $display("FAIL reset_mid valid=%b data=%0h primed=%b len_q=%0d want all zero",
               out_valid, out_data, primed, len_q);
    end
    model_reset();
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    for (int n = 0; n < 12; n++) begin
      cycle(1'b1, DW'($urandom), AW'(8));
      checks++;
      if ((n < 8 && out_data !== '0) || out_data !== e_data || primed !== e_primed || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL reset_resume n=%0d data=%0h primed=%b want %0h %b", n, out_data, primed, e_data, e_primed);
      end
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] dl;
    dl = AW'(6);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) dl = AW'($urandom_range(0, MD - 1));
      cycle(($urandom_range(0, 2) != 0), DW'($urandom), dl);
      checks++;
      if (out_valid !== e_valid || out_data !== e_data || primed !== e_primed || int'(len_q) !== m_len) begin
        errors++;
        $display("FAIL random i=%0d got v=%b d=%0h p=%b l=%0d want v=%b d=%0h p=%b l=%0d",
                 i, out_valid, out_data, primed, len_q, e_valid, e_data, e_primed, m_len);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_gappy();
    test_len_change();
    test_wrap();
    test_reset_mid();
    test_random();
    @(negedge clk);
    in_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
